// File: rtl/flag_unit.sv
// flag_unit: registered Z/C/N/V flags with masked load, condition evaluation and a push/pop flag stack.
// Define FLAG_STACK_EN to build the stack, SP and sticky error flags; otherwise they read as 0.
module flag_unit #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               FI,
    input  logic [DATA_W-1:0]                  ALU_RES,
    input  logic                               ALU_C,
    input  logic                               ALU_V,
    input  logic [3:0]                         FMASK,
    input  logic                               FPUSH,
    input  logic                               FPOP,
    input  logic [2:0]                         COND,
    output logic                               FZ,
    output logic                               FC,
    output logic                               FN,
    output logic                               FV,
    output logic                               COND_TRUE,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   SP,
    output logic                               STK_OVF,
    output logic                               STK_UNF
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    logic [3:0] flags, derived, loaded;
    logic [7:0] cond_vec;
    assign derived  = {ALU_V, ALU_RES[DATA_W-1], ALU_C, ALU_RES == '0};
    assign loaded   = FI ? (derived & FMASK) | (flags & ~FMASK) : flags;
    assign {FV, FN, FC, FZ} = flags;
    assign cond_vec = {FC & ~FZ, FV, FN, ~FC, FC, ~FZ, FZ, 1'b1};
    assign COND_TRUE = cond_vec[COND];
`ifdef FLAG_STACK_EN
    localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);
    logic [3:0] stack [0:(1<<IDX_W)-1];
    logic [SP_W-1:0] sp;
    logic ovf, unf, push_only, pop_only, do_push, do_pop;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    // simultaneous push and pop cancel out and raise no error
    assign push_only = FPUSH & ~FPOP;
    assign pop_only  = FPOP & ~FPUSH;
    assign do_push   = push_only & (sp != SP_MAX);
    assign do_pop    = pop_only & (sp != '0);
    assign wr_idx    = sp[IDX_W-1:0];
    assign rd_idx    = wr_idx - 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
            sp    <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            flags <= do_pop ? stack[rd_idx] : loaded;
            sp    <= do_push ? sp + 1'b1 : do_pop ? sp - 1'b1 : sp;
            ovf   <= ovf | (push_only & (sp == SP_MAX));
            unf   <= unf | (pop_only & (sp == '0));
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && do_push) stack[wr_idx] <= flags;
    end
    assign SP      = sp;
    assign STK_OVF = ovf;
    assign STK_UNF = unf;
`else
    logic unused_stack;
    assign unused_stack = FPUSH | FPOP;
    always_ff @(posedge clk) begin
        if (rst) flags <= '0;
        else flags <= loaded;
    end
    assign SP      = '0;
    assign STK_OVF = 1'b0;
    assign STK_UNF = 1'b0;
`endif
endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter DATA_W, default 8, ALU result width in bits (legal range 2..32).
REQ-002 Parameter STACK_DEPTH, default 4, number of flag-stack entries (legal range 1..16).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 FI  input  1  flag load enable.
REQ-006 ALU_RES  input  DATA_W  ALU result, used to derive Z and N.
REQ-007 ALU_C  input  1  ALU carry out.
REQ-008 ALU_V  input  1  ALU signed overflow.
REQ-009 FMASK  input  4  per-flag write mask, bit order {V,N,C,Z}.
REQ-010 FPUSH  input  1  push current flags onto the flag stack.
REQ-011 FPOP  input  1  pop the top stack entry into the flags.
REQ-012 COND  input  3  condition-code select.
REQ-013 FZ, FC, FN, FV  output  1 each  registered zero, carry, negative and overflow flags.
REQ-014 COND_TRUE  output  1  selected condition evaluated on the registered flags.
REQ-015 SP  output  $clog2(STACK_DEPTH+1)  stack occupancy count.
REQ-016 STK_OVF, STK_UNF  output  1 each  sticky stack overflow and underflow errors.

Function
REQ-017 Derived flags: Z = (ALU_RES == 0); N = ALU_RES[DATA_W-1]; C = ALU_C; V = ALU_V.
REQ-018 FI=1: each flag whose FMASK bit is 1 loads its derived value at the next edge; masked-off flags hold; FI=0: all flags hold.
REQ-019 Latency: an updated flag is visible one cycle after the FI edge; there is no combinational path from ALU inputs to the flag outputs.
REQ-020 COND_TRUE is combinational from the registered flags: 0 always 1; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 V; 7 C & !Z.
REQ-021 FPUSH alone, SP<STACK_DEPTH: {FV,FN,FC,FZ} as held before the edge is written at index SP, and SP increments.
REQ-022 FPUSH together with FI: the pre-update flags are pushed, and the FI update applies in the same cycle.
REQ-023 FPOP alone, SP>0: the flags load entry SP-1, and SP decrements.
REQ-024 FPOP together with FI, SP>0: the popped value wins for all four flags, and FI is ignored.
REQ-025 FPUSH and FPOP in the same cycle: the stack and SP are unchanged; FI applies normally.
REQ-026 FPUSH when SP==STACK_DEPTH: no write; SP holds; STK_OVF is set; FI applies normally.
REQ-027 FPOP when SP==0: flags are not restored; SP holds; STK_UNF is set; FI applies normally.
REQ-028 STK_OVF and STK_UNF stay set until reset; later legal operations do not clear them.

Reset
REQ-029 rst=1 at an edge sets FZ, FC, FN, FV to 0, SP to 0, and STK_OVF and STK_UNF to 0, regardless of all other inputs.
REQ-030 Stack entry contents need not be reset; they are unobservable until written.
REQ-031 rst asserted during a push or pop: reset wins, and the operation has no effect.
REQ-032 After reset, COND_TRUE equals 1 for COND=0, 2 and 4, and 0 for all other codes.

Configuration
REQ-033 Macro FLAG_STACK_EN defined: the flag stack, SP and the error flags are implemented as in REQ-021..REQ-028.
REQ-034 FLAG_STACK_EN undefined: no stack storage; FPUSH and FPOP are ignored; SP, STK_OVF and STK_UNF are tied to 0; all ports remain present.

Verification
REQ-035 Zero/negative: reset; FI=1, FMASK=4'hF, ALU_RES=8'h00, C=1 -> next cycle FZ=1, FC=1, FN=0, FV=0, COND=7 gives COND_TRUE=0.
REQ-036 Mask: from FZ=1,FC=1; FI=1, FMASK=4'b0100, ALU_RES=8'h80 -> FN=1, while FZ=1 and FC=1 hold.
REQ-037 Push/pop round trip: flags=4'b0101; FPUSH with FI loading ALU_RES=8'h01, C=0, V=0, FMASK=4'hF -> flags=0, SP=1; then FPOP -> flags=4'b0101, SP=0.
REQ-038 Overflow: with STACK_DEPTH=4, apply 5 consecutive FPUSH -> SP=4 and STK_OVF=1 from the 5th edge; then FPOP -> SP=3 and STK_OVF remains 1.
REQ-039 Underflow and simultaneous operations: FPOP at SP=0 -> STK_UNF=1, flags unchanged; FPUSH+FPOP at SP=2 -> SP stays 2.
REQ-040 Reset mid-operation: rst=1 with FPUSH=1 and FI=1 -> all flags 0, SP=0, error flags 0; rerun REQ-037 with the macro undefined -> SP stays 0 and FPOP leaves flags unchanged.
